accel_mem_arbiter: RTL and testbench

- Shares port A of the accelerator's local dual-port RAM between two requesters: the CPU bus slave and the accelerator FSM (keccak sequencer).
- Port B stays hard-wired to the accelerator and is outside this block.
- Grants at most one requester per cycle and routes read data back with the RAM's 1-cycle read latency.
- Bounds CPU starvation while the accelerator holds a burst lock.

---
 rtl/cfg_types_pkg.sv | 19 +
 rtl/accel_arb_starve_cnt.sv | 63 ++++++
 rtl/accel_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_accel_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_types_pkg.sv
// Shared arbiter types: state and owner enums plus the starvation counter width.
// No ports; imported by accel_mem_arbiter and accel_arb_starve_cnt.
package cfg_types_pkg;

  typedef enum logic [1:0] {
    ARB_FREE,
    ARB_LOCKED,
    ARB_FORCE
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_ACC
  } arb_owner_t;

  localparam int ARB_WAIT_W = 8;

endpackage

// File: rtl/accel_arb_starve_cnt.sv
// CPU starvation counter: counts refused CPU cycles and raises force_req on reaching MAX_WAIT.
// Ports: clk, rst_n, cpu_req, cpu_gnt in; force_req out; cpu_stall_cnt/force_cnt when ACCEL_ARB_STATS_EN.
module accel_arb_starve_cnt
  import cfg_types_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_gnt,
  output logic        force_req
`ifdef ACCEL_ARB_STATS_EN
  ,
  output logic [15:0] cpu_stall_cnt,
  output logic [15:0] force_cnt
`endif
);

  localparam logic [ARB_WAIT_W-1:0] LIMIT = ARB_WAIT_W'(MAX_WAIT);

  logic [ARB_WAIT_W-1:0] wait_cnt;
  logic [ARB_WAIT_W-1:0] wait_nxt;
  logic                  stall;

  assign stall = cpu_req & ~cpu_gnt;

  // Fires on the refusal that brings wait_cnt up to LIMIT, so the
  // force cycle is the very next one.
  assign force_req = stall & (wait_cnt == LIMIT - 1'b1);

  always_comb begin
    wait_nxt = '0;
    if (stall) begin
      wait_nxt = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_nxt;
    end
  end

`ifdef ACCEL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_stall_cnt <= '0;
      force_cnt     <= '0;
    end else begin
      if (stall && cpu_stall_cnt != 16'hFFFF) begin
        cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
      end
      if (force_req && force_cnt != 16'hFFFF) begin
        force_cnt <= force_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: rtl/accel_mem_arbiter.sv
// Port-A arbiter for the accelerator RAM: CPU vs keccak sequencer, with burst lock and starvation force.
// Ports: cpu_* / acc_* request+response sides, mem_*_a RAM port A; stats outputs with ACCEL_ARB_STATS_EN.
module accel_mem_arbiter
  import cfg_types_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  output logic                    cpu_gnt,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic                    cpu_we,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_be,
  output logic                    cpu_rvalid,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  input  logic                    acc_lock,
  input  logic                    acc_req,
  output logic                    acc_gnt,
  input  logic [ADDR_WIDTH-1:0]   acc_addr,
  input  logic                    acc_we,
  input  logic [DATA_WIDTH-1:0]   acc_wdata,
  input  logic [DATA_WIDTH/8-1:0] acc_be,
  output logic                    acc_rvalid,
  output logic [DATA_WIDTH-1:0]   acc_rdata,
  output logic                    mem_en_a,
  output logic [ADDR_WIDTH-1:0]   mem_addr_a,
  output logic                    mem_we_a,
  output logic [DATA_WIDTH-1:0]   mem_wdata_a,
  output logic [DATA_WIDTH/8-1:0] mem_be_a,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_a
`ifdef ACCEL_ARB_STATS_EN
  ,
  output logic [15:0]             cpu_stall_cnt,
  output logic [15:0]             force_cnt
`endif
);

  arb_state_t state;
  arb_state_t state_nxt;
  arb_owner_t last_owner;
  arb_owner_t resp_owner;
  arb_owner_t grant;
  logic       force_req;

  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] acc_rdata_q;

  accel_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_gnt      (cpu_gnt),
    .force_req    (force_req)
`ifdef ACCEL_ARB_STATS_EN
    ,
    .cpu_stall_cnt(cpu_stall_cnt),
    .force_cnt    (force_cnt)
`endif
  );

  always_comb begin
    grant = OWN_NONE;
    if (rst_n) begin
      case (state)
        ARB_FORCE: begin
          if (cpu_req) grant = OWN_CPU;
        end
        ARB_LOCKED: begin
          if (acc_req)      grant = OWN_ACC;
          else if (cpu_req) grant = OWN_CPU;
        end
        ARB_FREE: begin
          // Conflict goes to whoever did not win last; NONE favours CPU.
          if (cpu_req && acc_req)
            grant = (last_owner == OWN_CPU) ? OWN_ACC : OWN_CPU;
          else if (cpu_req) grant = OWN_CPU;
          else if (acc_req) grant = OWN_ACC;
        end
        default: grant = OWN_NONE;
      endcase
    end
  end

  // Force wins over a simultaneous lock change; the force cycle
  // then exits according to the lock sampled in that cycle.
  always_comb begin
    state_nxt = acc_lock ? ARB_LOCKED : ARB_FREE;
    if (force_req) state_nxt = ARB_FORCE;
  end

  assign cpu_gnt  = (grant == OWN_CPU);
  assign acc_gnt  = (grant == OWN_ACC);
  assign mem_en_a = cpu_gnt | acc_gnt;

  always_comb begin
    mem_addr_a  = '0;
    mem_we_a    = 1'b0;
    mem_wdata_a = '0;
    mem_be_a    = '1;
    unique case (1'b1)
      cpu_gnt: begin
        mem_addr_a  = cpu_addr;
        mem_we_a    = cpu_we;
        mem_wdata_a = cpu_wdata;
        mem_be_a    = cpu_be;
      end
      acc_gnt: begin
        mem_addr_a  = acc_addr;
        mem_we_a    = acc_we;
        mem_wdata_a = acc_wdata;
        mem_be_a    = acc_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_FREE;
      last_owner <= OWN_NONE;
      resp_owner <= OWN_NONE;
    end else begin
      state      <= state_nxt;
      resp_owner <= grant;
      if (grant != OWN_NONE) last_owner <= grant;
    end
  end

  // Gated by rst_n so a response still in flight when reset hits is dropped.
  assign cpu_rvalid = rst_n & (resp_owner == OWN_CPU);
  assign acc_rvalid = rst_n & (resp_owner == OWN_ACC);

  assign cpu_rdata = cpu_rvalid ? mem_rdata_a : cpu_rdata_q;
  assign acc_rdata = acc_rvalid ? mem_rdata_a : acc_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      acc_rdata_q <= '0;
    end else begin
      cpu_rdata_q <= cpu_rdata;
      acc_rdata_q <= acc_rdata;
    end
  end

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Testbench for accel_mem_arbiter: RAM model, response scoreboard, directed arbitration scenarios.
// Stats outputs checked only when ACCEL_ARB_STATS_EN is defined.
module tb_accel_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_gnt;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        acc_lock;
  logic        acc_req;
  logic        acc_gnt;
  logic [31:0] acc_addr;
  logic        acc_we;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_rvalid;
  logic [31:0] acc_rdata;
  logic        mem_en_a;
  logic [31:0] mem_addr_a;
  logic        mem_we_a;
  logic [31:0] mem_wdata_a;
  logic [3:0]  mem_be_a;
  logic [31:0] mem_rdata_a;
`ifdef ACCEL_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt;
  logic [15:0] force_cnt;
`endif

  accel_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_gnt    (cpu_gnt),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_be     (cpu_be),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .acc_lock   (acc_lock),
    .acc_req    (acc_req),
    .acc_gnt    (acc_gnt),
    .acc_addr   (acc_addr),
    .acc_we     (acc_we),
    .acc_wdata  (acc_wdata),
    .acc_be     (acc_be),
    .acc_rvalid (acc_rvalid),
    .acc_rdata  (acc_rdata),
    .mem_en_a   (mem_en_a),
    .mem_addr_a (mem_addr_a),
    .mem_we_a   (mem_we_a),
    .mem_wdata_a(mem_wdata_a),
    .mem_be_a   (mem_be_a),
    .mem_rdata_a(mem_rdata_a)
`ifdef ACCEL_ARB_STATS_EN
    ,
    .cpu_stall_cnt(cpu_stall_cnt),
    .force_cnt    (force_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_stall = 0;
  int exp_force = 0;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t acc_q[$];

  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  logic [31:0] ram_rd;

  assign mem_rdata_a = ram_rd;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_a[b]) ram[mem_addr_a[5:0]][8*b +: 8] <= mem_wdata_a[8*b +: 8];
      end else begin
        ram_rd <= ram[mem_addr_a[5:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[5:0]][8*b +: 8] = d[8*b +: 8];
  endtask

  // Response monitor: an rvalid is required exactly in the cycle the
  // scoreboard front entry names, and never otherwise.
  always @(negedge clk) begin
    bit e;
    e = (cpu_q.size() > 0) && (cpu_q[0].cyc == cyc);
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e});
    if (e) begin
      if (cpu_q[0].rd) chk("cpu_rdata", cpu_rdata, cpu_q[0].data);
      void'(cpu_q.pop_front());
    end
    e = (acc_q.size() > 0) && (acc_q[0].cyc == cyc);
    chk("acc_rvalid", {31'd0, acc_rvalid}, {31'd0, e});
    if (e) begin
      if (acc_q[0].rd) chk("acc_rdata", acc_rdata, acc_q[0].data);
      void'(acc_q.pop_front());
    end
  end

  task automatic cycle(input logic eg_c, input logic eg_a, input string tag);
    @(negedge clk);
    chk({tag, "_cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, eg_c});
    chk({tag, "_acc_gnt"}, {31'd0, acc_gnt}, {31'd0, eg_a});
    chk({tag, "_mem_en"}, {31'd0, mem_en_a}, {31'd0, eg_c | eg_a});
    if (eg_c) begin
      chk({tag, "_addr"}, mem_addr_a, cpu_addr);
      chk({tag, "_we"}, {31'd0, mem_we_a}, {31'd0, cpu_we});
      chk({tag, "_be"}, {28'd0, mem_be_a}, {28'd0, cpu_be});
      if (cpu_we) chk({tag, "_wdata"}, mem_wdata_a, cpu_wdata);
      cpu_q.push_back('{cyc + 1, !cpu_we, ref_mem[cpu_addr[5:0]]});
      if (cpu_we) ref_write(cpu_addr, cpu_wdata, cpu_be);
    end else if (eg_a) begin
      chk({tag, "_addr"}, mem_addr_a, acc_addr);
      chk({tag, "_we"}, {31'd0, mem_we_a}, {31'd0, acc_we});
      chk({tag, "_be"}, {28'd0, mem_be_a}, {28'd0, acc_be});
      if (acc_we) chk({tag, "_wdata"}, mem_wdata_a, acc_wdata);
      acc_q.push_back('{cyc + 1, !acc_we, ref_mem[acc_addr[5:0]]});
      if (acc_we) ref_write(acc_addr, acc_wdata, acc_be);
    end else begin
      chk({tag, "_idle_addr"}, mem_addr_a, 32'd0);
      chk({tag, "_idle_be"}, {28'd0, mem_be_a}, 32'hF);
      chk({tag, "_idle_we"}, {31'd0, mem_we_a}, 32'd0);
    end
    if (rst_n && cpu_req && !eg_c) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_addr = '0; cpu_we = 1'b0;
    cpu_wdata = '0; cpu_be = 4'hF;
    acc_lock = 1'b0; acc_req = 1'b1; acc_addr = '0;
    acc_we = 1'b0; acc_wdata = '0; acc_be = 4'hF;
    ram_rd = '0;
    for (int i = 0; i < 64; i++) begin
      ram[i] = 32'hC0DE_0000 | i;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    @(posedge clk);
    #1;
    cycle(0, 0, "rst0");
    cycle(0, 0, "rst1");
    rst_n = 1'b1;
    cpu_req = 1'b0;
    acc_req = 1'b0;
    exp_stall = 0;

    // Single CPU read
    cpu_req = 1'b1; cpu_addr = 32'h4;
    cycle(1, 0, "cpu_rd");
    cpu_req = 1'b0;
    cycle(0, 0, "idle_a");

    // Accelerator partial write
    acc_req = 1'b1; acc_we = 1'b1; acc_addr = 32'h10;
    acc_wdata = 32'h12345678; acc_be = 4'b0011;
    cycle(0, 1, "acc_wr");
    acc_req = 1'b0; acc_we = 1'b0; acc_be = 4'hF;
    cycle(0, 0, "idle_b");

    // Round-robin conflict, last owner is ACC
    cpu_req = 1'b1;
    acc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        cpu_addr = 32'(8 + i);
        acc_addr = 32'(20 + i);
      end
      cycle(i % 2 == 0, i % 2 == 1, "rr");
    end
    cpu_req = 1'b0;
    acc_req = 1'b0;
    cycle(0, 0, "idle_c");

    // Locked, acc_req toggling
    acc_lock = 1'b1;
    cycle(0, 0, "lock_on");
    cpu_req = 1'b1; cpu_addr = 32'h5;
    acc_req = 1'b1; acc_addr = 32'd31;
    cycle(0, 1, "tog1");
    acc_req = 1'b0;
    cycle(1, 0, "tog0");
    cpu_req = 1'b0; acc_req = 1'b1; acc_addr = 32'd32;
    cycle(0, 1, "tog1b");

    // Reset in the middle of a locked burst
    acc_addr = 32'd33;
    cycle(0, 1, "burst");
    rst_n = 1'b0;
    cpu_req = 1'b1;
    cpu_q.delete();
    acc_q.delete();
    cycle(0, 0, "rst_mid0");
    cycle(0, 0, "rst_mid1");
    rst_n = 1'b1;
    acc_lock = 1'b0;
    exp_stall = 0;
    exp_force = 0;
    cpu_addr = 32'd6;
    acc_addr = 32'd34;
    cycle(1, 0, "post_rst");
    cpu_req = 1'b0;
    cycle(0, 1, "post_rst_acc");
    acc_req = 1'b0;
    cycle(0, 0, "idle_d");

    // Starvation force under lock; CPU reads back the partial write
    acc_lock = 1'b1;
    cycle(0, 0, "lock_on2");
    cpu_req = 1'b1; cpu_addr = 32'h10;
    acc_req = 1'b1; acc_addr = 32'd40;
    for (int i = 0; i < 8; i++) cycle(0, 1, "starve");
    exp_force++;
    cycle(1, 0, "force");
    cpu_req = 1'b0;
    cycle(0, 1, "resume");
    acc_req = 1'b0;
    acc_lock = 1'b0;
    cycle(0, 0, "idle_e");
    cycle(0, 0, "idle_f");

`ifdef ACCEL_ARB_STATS_EN
    chk("stall_cnt", {16'd0, cpu_stall_cnt}, 32'(exp_stall));
    chk("force_cnt", {16'd0, force_cnt}, 32'(exp_force));
`endif
    chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    chk("acc_q_empty", 32'(acc_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
